serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single 1-bit full-adder slice (two half adders plus carry OR) over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start request, shifts them through the slice while holding the carry in a flip-flop, and presents the registered sum and carry-out with a one-cycle done pulse. It is the sequencing layer above the lab adder datapath and trades latency for a single adder cell.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to add a and b; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high in ADD and DONE states.
- done  output  1  one-cycle pulse; sum and cout are valid while it is high.
- sum  output  WIDTH  registered result, a+b modulo 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- States: IDLE, ADD, DONE. The encoding is 2-bit, with IDLE=0, ADD=1, and DONE=2. Code 3 is illegal and returns to IDLE on the next edge.
- IDLE, start=1:
  - Latch a into shift register ra and b into rb.
  - Clear the carry flop and the bit counter cnt.
  - Clear the sum shift register.
  - Go to ADD.
- IDLE, start=0: hold all state. sum and cout keep the last result.
- ADD, each edge:
  - The slice computes s = ra[0]^rb[0]^c and co = majority(ra[0], rb[0], c).
  - Shift ra and rb right by 1.
  - Shift s into the MSB of the sum register, right-shifting it.
  - Set c <= co and cnt <= cnt+1.
- ADD, on the edge where cnt = WIDTH-1 (the WIDTH-th bit):
  - Go to DONE.
  - Set cout <= co.
  - After this edge, the sum register holds the full result in natural order.
- DONE: done=1 for exactly this one cycle. The next edge goes to IDLE unconditionally.
- start is ignored in ADD and DONE. Requests are not queued, and the operand inputs are not re-sampled.
- Operands may change freely after the accepted start edge; the latched copies are used.
- cnt width is $clog2(WIDTH). cnt does not wrap within an operation because the exit condition is cnt = WIDTH-1.
- Reset state (asynchronous, any time):
  - State IDLE.
  - ra, rb, c and cnt at 0.
  - sum=0, cout=0, done=0, busy=0.
- Reset mid-operation aborts the addition. No done pulse is produced, and the partial sum is discarded because sum is forced to 0.

## Timing
- Accepted start edge is T0. busy=1 from T0 through T0+WIDTH+1.
- Bits 0..WIDTH-1 are processed on edges T0+1 .. T0+WIDTH.
- done=1 in the cycle following edge T0+WIDTH. The next edge, T0+WIDTH+1, returns to IDLE.
- Earliest next accepted start is edge T0+WIDTH+2. Throughput is one addition per WIDTH+2 cycles.
- busy, done, sum and cout are all registered. No output is combinational from an input.
- During ADD, sum shows partial shifted data and must be used only when done=1 or in IDLE.

## Structure
- Shared package/header holds:
  - State localparams ST_IDLE, ST_ADD and ST_DONE.
  - A 2-bit state width constant.
  - The default WIDTH.
- One sub-module: serial_bit_adder, a 1-bit full adder built from two half-adder instances plus an OR for carry. It is purely combinational.
- serial_adder_ctrl holds the FSM, counter, shift registers and carry flop, and instantiates serial_bit_adder once.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, start for 1 cycle -> done at T0+9 cycles after start edge, sum=8'h10, cout=0; busy high 9 cycles.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'h00, b=8'h00 -> sum=8'h00, cout=0 (carry flop cleared between ops).
- a=8'hA5, b=8'h5A, then start pulsed with a=8'h01, b=8'h01 at T0+3 -> second start ignored; result sum=8'hFF, cout=0; exactly one done pulse.
- start held high continuously with a=8'h80, b=8'h80 -> back-to-back ops every 10 cycles, each giving sum=8'h00, cout=1.
- rst asserted at T0+4 of a=8'h33+8'h44 op -> busy, done, sum and cout go 0 immediately, with no done pulse. A new start after release gives a correct result.
- Randomized 200 operand pairs against a reference a+b model -> {cout,sum} matches on every done pulse.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM state codes, state width and default operand width.
// Pure declarations: no latency and no flow control of its own.
package serial_adder_ctrl_pkg;

  localparam int ST_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_bit_adder.sv
// One-bit full-adder slice built from two half adders and a carry OR.
// Purely combinational: zero latency, no backpressure.
module serial_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_bit_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  serial_half_adder u_ha0 (
    .x (x),
    .y (y),
    .s (ha0_s),
    .c (ha0_c)
  );

  serial_half_adder u_ha1 (
    .x (ha0_s),
    .y (cin),
    .s (s),
    .c (ha1_c)
  );

  // The two half-adder carries can never both be set, so OR gives the majority.
  assign co = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: latches a/b on start, adds LSB first through one slice, pulses done with {cout,sum}.
// Latency WIDTH+1 cycles from the accepted start edge; start is ignored (not queued) while busy.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               cout_q, cout_d;

  logic               slice_s;
  logic               slice_co;
  logic               last_bit;

  serial_bit_adder u_slice (
    .x   (ra_q[0]),
    .y   (rb_q[0]),
    .cin (c_q),
    .s   (slice_s),
    .co  (slice_co)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ADD;
      ST_ADD:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ADD) || (state_q == ST_DONE);
    done = (state_q == ST_DONE);
    sum  = sum_q;
    cout = cout_q;
  end

  always_comb begin
    ra_d   = ra_q;
    rb_d   = rb_q;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    c_d    = c_q;
    cout_d = cout_q;
    if (state_q == ST_IDLE && start) begin
      ra_d  = a;
      rb_d  = b;
      sum_d = '0;
      cnt_d = '0;
      c_d   = 1'b0;
    end else if (state_q == ST_ADD) begin
      ra_d  = ra_q >> 1;
      rb_d  = rb_q >> 1;
      // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
      sum_d = {slice_s, sum_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      c_d   = slice_co;
      if (last_bit) cout_d = slice_co;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q   <= '0;
      rb_q   <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus randomized operands against a+b.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One start pulse, operands scrambled right after acceptance; checks latency, busy length and result.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
    int         lat;
    int         busy_cnt;
    logic [W:0] expv;
    expv = {1'b0, xa} + {1'b0, xb};
    @(negedge clk);
    start = 1'b1; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, 64'(lat), 64'(W + 1));
    check({tag, " result"}, 64'({cout, sum}), 64'(expv));
    @(negedge clk);
    check({tag, " idle"}, 64'({busy, done}), 64'd0);
    check({tag, " held"}, 64'({cout, sum}), 64'(expv));
    check({tag, " busy_len"}, 64'(busy_cnt), 64'(W + 1));
  endtask

  initial begin
    int done_cnt;
    int last_done;
    logic [W:0] got_res;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("reset outs", 64'({busy, done, cout, sum}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post reset idle", 64'({busy, done, cout, sum}), 64'd0);

    run_op(8'h0F, 8'h01, "0f+01");
    run_op(8'hFF, 8'h01, "ff+01");
    run_op(8'h00, 8'h00, "00+00");

    // Second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; got_res = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (c == 4) start = 1'b0;
      if (done) begin done_cnt++; got_res = {cout, sum}; end
    end
    check("ignore start dones", 64'(done_cnt), 64'd1);
    check("ignore start result", 64'(got_res), 64'h0FF);

    // Start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80;
    done_cnt = 0; last_done = -1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (done) begin
        check("b2b result", 64'({cout, sum}), 64'h100);
        if (last_done >= 0) check("b2b spacing", 64'(c - last_done), 64'(W + 2));
        last_done = c;
        done_cnt++;
      end
    end
    start = 1'b0;
    check("b2b count", 64'(done_cnt), 64'd3);
    for (int c = 0; c < 4 * W && busy; c++) @(negedge clk);
    check("b2b drained", 64'(busy), 64'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h44;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset outs", 64'({busy, done, cout, sum}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid reset no done", 64'(done_cnt), 64'd0);
    run_op(8'h33, 8'h44, "after reset");

    for (int i = 0; i < 200; i++) begin
      run_op(W'($urandom), W'($urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
